// File: rtl/drr_pkg.sv
// Shared definitions for the DRR packet queues, the scheduler and the tester.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package drr_pkg;

  localparam int PKT_QS_CNT = 4;
  localparam int SIZE_W     = 16;
  localparam int QID_W      = (PKT_QS_CNT > 1) ? $clog2(PKT_QS_CNT) : 1;

  typedef logic [QID_W-1:0]  qid_t;
  typedef logic [SIZE_W-1:0] pkt_size_t;

endpackage

// File: rtl/drr_pkt_fifo.sv
// One packet-size FIFO with a registered head entry and occupancy count.
// Latency: head_o/level_o update one cycle after push_i/pop_i.
// Backpressure: none internally; the parent only pushes when there is room
// (or a same-cycle pop) and only pops when level_o > 0.
// Ports: push_i/data_i write an entry, pop_i removes the head,
//        head_o is the head size (0 when empty), level_o the entry count.
module drr_pkt_fifo #(
  parameter int DEPTH  = 8,
  parameter int SIZE_W = 16
) (
  input  logic                       clk_i,
  input  logic                       srst_i,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [SIZE_W-1:0]          data_i,
  output logic [SIZE_W-1:0]          head_o,
  output logic [$clog2(DEPTH+1)-1:0] level_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH+1);

  logic [SIZE_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  rd_nxt;
  logic [LVL_W-1:0]  cnt_q, cnt_d;
  logic [SIZE_W-1:0] head_q, head_d;

  always_comb begin
    // DEPTH is a power of two, so pointers wrap by plain overflow.
    rd_nxt   = rd_ptr_q + 1'b1;
    wr_ptr_d = push_i ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop_i ? rd_nxt : rd_ptr_q;

    cnt_d = cnt_q;
    if (push_i && !pop_i) begin
      cnt_d = cnt_q + 1'b1;
    end else if (pop_i && !push_i) begin
      cnt_d = cnt_q - 1'b1;
    end

    // Head is precomputed so it is ready as a flop output next cycle.
    // When the only stored entry is popped while a new one arrives, the
    // new entry bypasses storage straight into the head register.
    head_d = head_q;
    if (cnt_d == '0) begin
      head_d = '0;
    end else if (pop_i) begin
      head_d = (cnt_q == LVL_W'(1)) ? data_i : mem_q[rd_nxt];
    end else if (push_i && cnt_q == '0) begin
      head_d = data_i;
    end
  end

  // Storage is not reset; pointers and count alone define what is valid.
  always_ff @(posedge clk_i) begin
    if (push_i) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      head_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      head_q   <= head_d;
    end
  end

  assign head_o  = head_q;
  assign level_o = cnt_q;

endmodule

// File: rtl/drr_pkt_queues.sv
// Bank of per-queue packet-size FIFOs feeding a DRR scheduler.
// Latency: size_o/level_o reflect an accepted enqueue or pop one cycle later.
// Backpressure: enq_rdy_o drops for a full target queue (unless it is popped
// this cycle), for zero-size packets and during reset; rejects are counted.
// Ports: enq_* is the enqueue request, read_i/read_val_i the pop from the
//        scheduler, size_o/level_o per-queue head size and occupancy,
//        drop_cnt_o the saturating reject count, err_o a sticky empty-pop flag.
module drr_pkt_queues #(
  parameter int PKT_QS_CNT  = drr_pkg::PKT_QS_CNT,
  parameter int QUEUE_DEPTH = 8,
  parameter int SIZE_W      = drr_pkg::SIZE_W
) (
  input  logic                                             clk_i,
  input  logic                                             srst_i,
  input  logic                                             enq_val_i,
  input  logic [$clog2(PKT_QS_CNT)-1:0]                    enq_qid_i,
  input  logic [SIZE_W-1:0]                                enq_size_i,
  output logic                                             enq_rdy_o,
  input  logic [$clog2(PKT_QS_CNT)-1:0]                    read_i,
  input  logic                                             read_val_i,
  output logic [PKT_QS_CNT-1:0][SIZE_W-1:0]                size_o,
  output logic [PKT_QS_CNT-1:0][$clog2(QUEUE_DEPTH+1)-1:0] level_o,
  output logic [15:0]                                      drop_cnt_o,
  output logic                                             err_o
);

  localparam int QID_W = $clog2(PKT_QS_CNT);
  localparam int LVL_W = $clog2(QUEUE_DEPTH+1);

  logic [PKT_QS_CNT-1:0] push, pop;
  logic [LVL_W-1:0]      rd_lvl, tgt_lvl;
  logic                  pop_ok;
  logic                  same_q_pop;
  logic [15:0]           drop_cnt_q, drop_cnt_d;
  logic                  err_q, err_d;

  always_comb begin
    // Levels of the addressed queues; an out-of-range index reads as empty.
    rd_lvl  = '0;
    tgt_lvl = '0;
    for (int q = 0; q < PKT_QS_CNT; q++) begin
      if (QID_W'(q) == read_i)    rd_lvl  = level_o[q];
      if (QID_W'(q) == enq_qid_i) tgt_lvl = level_o[q];
    end

    pop_ok     = !srst_i && read_val_i && (rd_lvl != '0);
    same_q_pop = pop_ok && (read_i == enq_qid_i);

    // A full queue still takes a packet when its head leaves the same cycle.
    enq_rdy_o = !srst_i && enq_val_i && (enq_size_i != '0) &&
                ((tgt_lvl != LVL_W'(QUEUE_DEPTH)) || same_q_pop);

    for (int q = 0; q < PKT_QS_CNT; q++) begin
      push[q] = enq_rdy_o && (enq_qid_i == QID_W'(q));
      pop[q]  = pop_ok && (read_i == QID_W'(q));
    end

    drop_cnt_d = drop_cnt_q;
    if (!srst_i && enq_val_i && !enq_rdy_o && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_d = drop_cnt_q + 16'd1;
    end

    err_d = err_q | (!srst_i && read_val_i && (rd_lvl == '0));
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      drop_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
      err_q      <= err_d;
    end
  end

  assign drop_cnt_o = drop_cnt_q;
  assign err_o      = err_q;

  for (genvar g = 0; g < PKT_QS_CNT; g++) begin : g_q
    drr_pkt_fifo #(
      .DEPTH  (QUEUE_DEPTH),
      .SIZE_W (SIZE_W)
    ) u_fifo (
      .clk_i   (clk_i),
      .srst_i  (srst_i),
      .push_i  (push[g]),
      .pop_i   (pop[g]),
      .data_i  (enq_size_i),
      .head_o  (size_o[g]),
      .level_o (level_o[g])
    );
  end

endmodule

// File: tb/tb_drr_pkt_queues.sv
module tb_drr_pkt_queues;

  localparam int NQ    = 4;
  localparam int DEPTH = 8;
  localparam int SW    = 16;
  localparam int LW    = 4;

  logic                      clk = 1'b0;
  logic                      srst = 1'b1;
  logic                      enq_val = 1'b0;
  logic [1:0]                enq_qid = '0;
  logic [SW-1:0]             enq_size = '0;
  logic                      enq_rdy;
  logic [1:0]                read = '0;
  logic                      read_val = 1'b0;
  logic [NQ-1:0][SW-1:0]     size_o;
  logic [NQ-1:0][LW-1:0]     level_o;
  logic [15:0]               drop_cnt;
  logic                      err;

  always #5 clk = ~clk;

  drr_pkt_queues #(.PKT_QS_CNT(NQ), .QUEUE_DEPTH(DEPTH), .SIZE_W(SW)) dut (
    .clk_i      (clk),
    .srst_i     (srst),
    .enq_val_i  (enq_val),
    .enq_qid_i  (enq_qid),
    .enq_size_i (enq_size),
    .enq_rdy_o  (enq_rdy),
    .read_i     (read),
    .read_val_i (read_val),
    .size_o     (size_o),
    .level_o    (level_o),
    .drop_cnt_o (drop_cnt),
    .err_o      (err)
  );

  typedef struct packed {
    logic                  rdy;
    logic [NQ-1:0][SW-1:0] size;
    logic [NQ-1:0][LW-1:0] lvl;
    logic [15:0]           drop;
    logic                  err;
  } exp_t;

  exp_t exp_q[$];

  // Reference model: each queue is a plain list of packet sizes.
  int mq[NQ][$];
  int m_drop = 0;
  bit m_err = 1'b0;

  int checks = 0;
  int passes = 0;

  function automatic void chk(string name, int act, int req);
    checks++;
    if (act == req) passes++;
    else $display("FAIL %s actual=%0d required=%0d", name, act, req);
  endfunction

  // Apply one cycle of stimulus and queue the model's expectation for it.
  task automatic step(input bit rst, input bit val, input int qid, input int sz,
                      input bit rv, input int rq);
    exp_t e;
    bit   pop_ok, rdy;
    @(negedge clk);
    srst     = rst;
    enq_val  = val;
    enq_qid  = 2'(qid);
    enq_size = 16'(sz);
    read_val = rv;
    read     = 2'(rq);
    rdy = 1'b0;
    if (rst) begin
      for (int q = 0; q < NQ; q++) mq[q].delete();
      m_drop = 0;
      m_err  = 1'b0;
    end else begin
      pop_ok = rv && (mq[rq].size() > 0);
      rdy = val && (sz != 0) && ((mq[qid].size() < DEPTH) || (pop_ok && rq == qid));
      if (pop_ok) void'(mq[rq].pop_front());
      if (rdy) mq[qid].push_back(sz);
      else if (val && m_drop < 65535) m_drop++;
      if (rv && !pop_ok) m_err = 1'b1;
    end
    e.rdy  = rdy;
    e.drop = 16'(m_drop);
    e.err  = m_err;
    for (int q = 0; q < NQ; q++) begin
      e.size[q] = (mq[q].size() > 0) ? 16'(mq[q][0]) : 16'd0;
      e.lvl[q]  = 4'(mq[q].size());
    end
    exp_q.push_back(e);
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: handshake checked mid-cycle, registered state after the edge.
  initial begin
    exp_t cur;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        cur = exp_q[0];
        chk("enq_rdy", int'(enq_rdy), int'(cur.rdy));
      end
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        cur = exp_q.pop_front();
        chk("drop_cnt", int'(drop_cnt), int'(cur.drop));
        chk("err", int'(err), int'(cur.err));
        for (int q = 0; q < NQ; q++) begin
          chk($sformatf("size[%0d]", q), int'(size_o[q]), int'(cur.size[q]));
          chk($sformatf("level[%0d]", q), int'(level_o[q]), int'(cur.lvl[q]));
        end
      end
    end
  end

  initial begin
    int def[NQ];
    int order;
    int pops;

    step(1, 0, 0, 0, 0, 0);
    step(1, 1, 1, 5, 1, 1);   // requests during reset are ignored

    // Three back-to-back enqueues to queue 2, then drain them.
    step(0, 1, 2, 100, 0, 0);
    step(0, 1, 2, 200, 0, 0);
    step(0, 1, 2, 300, 0, 0);
    idle();
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1, 2);
    idle();

    // Fill queue 0, overflow it, then overflow with a same-cycle pop.
    for (int i = 0; i < DEPTH; i++) step(0, 1, 0, 10 + i, 0, 0);
    step(0, 1, 0, 64, 0, 0);
    step(0, 1, 0, 64, 1, 0);
    idle();

    // Empty pop raises the sticky error; zero size is rejected.
    step(0, 0, 0, 0, 1, 3);
    step(0, 1, 1, 0, 0, 0);
    idle();
    idle();

    // Same-cycle enqueue and pop on a single-entry queue.
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, 1, 50, 0, 0);
    step(0, 1, 1, 70, 1, 1);
    idle();

    // Randomised traffic, including occasional mid-run reset.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0,
           $urandom_range(0, NQ - 1),
           ($urandom_range(0, 15) == 0) ? 0 : $urandom_range(1, 65535),
           $urandom_range(0, 2) == 0, $urandom_range(0, NQ - 1));
    end
    idle();

    // DRR service with quantum 500, driven from the DUT's head sizes.
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, 0, 300, 0, 0);
    step(0, 1, 1, 800, 0, 0);
    step(0, 1, 2, 200, 0, 0);
    step(0, 1, 3, 500, 0, 0);
    idle();
    order = 0;
    pops  = 0;
    for (int q = 0; q < NQ; q++) def[q] = 0;
    for (int r = 0; r < 4; r++) begin
      for (int q = 0; q < NQ; q++) begin
        @(posedge clk);
        #1;
        if (level_o[q] != 0) begin
          def[q] += 500;
          while (level_o[q] != 0 && int'(size_o[q]) <= def[q] && pops < 8) begin
            def[q] -= int'(size_o[q]);
            order = order * 10 + q + 1;
            pops++;
            step(0, 0, 0, 0, 1, q);
            idle();
            @(posedge clk);
            #1;
          end
          if (level_o[q] == 0) def[q] = 0;
        end
      end
    end
    chk("drr_order", order, 1342);
    idle();

    repeat (3) @(posedge clk);
    #2;
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/drr_pkt_queues.md
DRR_PKT_QUEUES -- requirements
Module: drr_pkt_queues

Interface
REQ-001 Parameter PKT_QS_CNT, default 4: number of packet queues feeding the DRR scheduler.
REQ-002 Parameter QUEUE_DEPTH, default 8: entries per queue, power of two, >= 2.
REQ-003 Parameter SIZE_W, default 16: packet size width in bytes.
REQ-004 clk_i  input  1  single clock; all logic on its rising edge.
REQ-005 srst_i  input  1  reset, synchronous and active-high.
REQ-006 enq_val_i  input  1  enqueue request.
REQ-007 enq_qid_i  input  $clog2(PKT_QS_CNT)  target queue of the enqueue.
REQ-008 enq_size_i  input  SIZE_W  packet size to enqueue.
REQ-009 enq_rdy_o  output  1  enqueue is accepted this cycle.
REQ-010 read_i  input  $clog2(PKT_QS_CNT)  queue to pop; driven by the scheduler's read address.
REQ-011 read_val_i  input  1  pop strobe; driven by the scheduler's read-valid output.
REQ-012 size_o  output  PKT_QS_CNT x SIZE_W  head-packet size per queue; 0 means the queue is empty.
REQ-013 level_o  output  PKT_QS_CNT x $clog2(QUEUE_DEPTH+1)  per-queue occupancy.
REQ-014 drop_cnt_o  output  16  count of rejected enqueues; saturates at 0xFFFF.
REQ-015 err_o  output  1  sticky flag set by a pop of an empty queue.

Function
REQ-016 Each queue SHALL be an independent FIFO of sizes with its own write pointer, read pointer and count; pointers wrap modulo QUEUE_DEPTH.
REQ-017 enq_rdy_o SHALL equal enq_val_i AND (target queue level < QUEUE_DEPTH OR a pop of that same queue is accepted this cycle) AND enq_size_i != 0.
REQ-018 An enqueue with enq_rdy_o low SHALL NOT change any queue, and SHALL increment drop_cnt_o by 1 on the next edge, saturating.
REQ-019 A pop SHALL be accepted when read_val_i=1 and level of queue read_i > 0; the head entry is removed at that edge.
REQ-020 A pop of an empty queue SHALL be ignored and SHALL set err_o at that edge; err_o clears only on reset.
REQ-021 size_o[q] SHALL be registered: it shows the new head one cycle after an accepted enqueue into empty queue q, or after an accepted pop.
REQ-022 size_o[q] SHALL be 0 whenever level_o[q]=0, including the cycle after the last entry is popped.
REQ-023 Simultaneous accepted enqueue and pop on the same queue SHALL leave level unchanged; with level 1, the enqueued packet becomes head on the next cycle.
REQ-024 With level = QUEUE_DEPTH, simultaneous enqueue and pop on that queue SHALL both be accepted.
REQ-025 Simultaneous enqueue and pop on different queues SHALL be independent.
REQ-026 level_o SHALL be a registered count equal to the number of stored entries.
REQ-027 Sizes SHALL be stored and presented unmodified; there is no arithmetic on sizes.

Reset
REQ-028 On srst_i=1 at a clock edge, all pointers, levels, size_o, drop_cnt_o and err_o SHALL become 0, and enq_rdy_o SHALL be 0 while srst_i=1.
REQ-029 Reset asserted mid-operation SHALL discard all stored packets; storage contents need not be cleared.
REQ-030 Requests presented in the reset cycle SHALL be ignored and SHALL NOT count as drops or errors.

Structure
REQ-031 Shared package drr_pkg SHALL hold PKT_QS_CNT, SIZE_W, typedef qid_t (queue index) and typedef pkt_size_t (SIZE_W bits); the scheduler and the tester use the same package.
REQ-032 One sub-module drr_pkt_fifo (single queue: storage, pointers, count, registered head) SHALL be instantiated PKT_QS_CNT times via generate; the top holds decode, accept logic, drop counter and error flag.

Verification
REQ-033 Reset, then enqueue 100, 200, 300 to queue 2 in consecutive cycles -> size_o[2]=100 one cycle after the first enqueue, level_o[2]=3, other size_o entries 0.
REQ-034 Pop queue 2 three times back-to-back -> size_o[2] shows 200, 300, then 0; err_o stays 0.
REQ-035 Fill queue 0 with 8 packets, then enqueue a 9th packet of size 64 -> enq_rdy_o=0, drop_cnt_o=1, level_o[0]=8; repeat with a simultaneous pop of queue 0 -> accepted, level stays 8.
REQ-036 Pop empty queue 3 -> err_o=1 and stays 1 until srst_i; enqueue size 0 -> rejected, drop_cnt_o increments.
REQ-037 Queue 1 holds one packet (size 50); enqueue 70 to queue 1 and pop queue 1 in the same cycle -> next cycle size_o[1]=70, level_o[1]=1.
REQ-038 Connected to deficit_round_robin with QUANTUM_SIZE 500: load sizes 300, 800, 200 and 500 into queues 0-3 -> pops follow DRR order; queue 1 is served in round 2; all queues drain with no error.
